hilo_mdu_ctrl: RTL and testbench

- Multiply/divide unit controller for the 5-stage MIPS pipeline, sitting in EX beside the ALU.
- Sequences MULT/MULTU (2-cycle) and DIV/DIVU (radix-2 iterative, 34 cycles).
- Owns the HI/LO architectural registers, services MTHI/MTLO, and raises an EX-stage stall while busy.
- An exception/eret flush aborts any in-flight operation without touching HI/LO.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/div_iter_step.sv | 39 +++
 rtl/hilo_mdu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared types and constants for the multiply/divide unit controller.
//   mdu_op_t     : operation code delivered by decode alongside the EX operands
//   mdu_state_t  : sequencer state of hilo_mdu_ctrl
//   DIV_ZERO_LO  : LO value written by a divide whose divisor is zero
//   cond_neg     : two's-complement negate when requested (sign fix-up helper)
// Enumerator names carry OP_/ST_ prefixes because both enums need a "DIV".
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_W = 32;

    localparam logic [MDU_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // Negate v when neg is set; used both for operand magnitudes and results.
    function automatic logic [MDU_W-1:0] cond_neg(input logic [MDU_W-1:0] v,
                                                  input logic             neg);
        logic [MDU_W-1:0] r;
        if (neg) begin
            r = {MDU_W{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// ---------------------------------------------------------------------------
// div_iter_step
// One combinational restoring-division step. The quotient register initially
// holds the dividend; each step shifts its MSB into the partial remainder and
// shifts the new quotient bit in at the LSB.
//   rem      in  W  partial remainder (always < divisor for a non-zero divisor)
//   quo      in  W  dividend bits not yet consumed / quotient bits produced
//   divisor  in  W  divisor magnitude
//   rem_nx   out W  partial remainder after this step
//   quo_nx   out W  quotient register after this step
// ---------------------------------------------------------------------------
module div_iter_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_nx,
    output logic [W-1:0] quo_nx
);

    logic [W:0] shifted_s;
    logic [W:0] diff_s;

    // Trial subtraction; a clear top bit of the W+1-bit difference means the
    // shifted remainder was at least the divisor, so the subtraction sticks.
    always_comb begin
        shifted_s = {rem, quo[W-1]};
        diff_s    = shifted_s - {1'b0, divisor};
        if (diff_s[W] == 1'b0) begin
            rem_nx = diff_s[W-1:0];
            quo_nx = {quo[W-2:0], 1'b1};
        end else begin
            rem_nx = shifted_s[W-1:0];
            quo_nx = {quo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_mdu_ctrl
// EX-stage multiply/divide controller owning the HI/LO registers.
//   MULT/MULTU : 2 cycles (issue registers the product, MUL writes HI/LO)
//   DIV/DIVU   : 34 cycles (issue, 32 restoring steps, DONE writes HI/LO)
//   MTHI/MTLO  : single-cycle write in IDLE, no stall
// A flush aborts any operation and suppresses every HI/LO write that cycle.
// Ports:
//   clk, rst (async, active-high), flush, ex_valid, mdu_op[2:0],
//   src_a, src_b            : EX operands (held stable by EX while stalled)
//   stall_e                 : combinational EX stall request
//   busy                    : sequencer is not idle
//   hi, lo                  : architectural HI/LO registers (no bypass)
// ---------------------------------------------------------------------------
module hilo_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [2:0]        mdu_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              stall_e,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    mdu_op_t             op_s;
    mdu_state_t          state_r;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_r;
    logic [DATA_W-1:0]   quo_r;
    logic [DATA_W-1:0]   rem_r;
    logic [DATA_W-1:0]   dvs_r;
    logic [DATA_W-1:0]   raw_a_r;
    logic                qneg_r;
    logic                rneg_r;
    logic [CNT_W-1:0]    count_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic                start_op_s;
    logic                issue_s;
    logic                stall_s;
    logic                div_signed_s;
    logic [DATA_W-1:0]   rem_nx_s;
    logic [DATA_W-1:0]   quo_nx_s;

    assign op_s = mdu_op_t'(mdu_op);

    // Decode which operations occupy the sequencer.
    always_comb begin
        start_op_s = 1'b0;
        case (op_s)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_op_s = 1'b1;
            default:                            start_op_s = 1'b0;
        endcase
    end

    assign issue_s      = (state_r == ST_IDLE) && ex_valid && !flush && start_op_s;
    assign div_signed_s = (op_s == OP_DIV);

    // 64-bit product; low 2*DATA_W bits of the extended operands give the
    // signed or unsigned full product.
    always_comb begin
        if (op_s == OP_MULT) begin
            prod_s = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};
        end else begin
            prod_s = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
        end
    end

    // Stall EX on issue and through every divide step; flush always wins.
    always_comb begin
        stall_s = 1'b0;
        if (flush) begin
            stall_s = 1'b0;
        end else if (issue_s) begin
            stall_s = 1'b1;
        end else if (state_r == ST_DIV) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    div_iter_step #(.W(DATA_W)) u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .divisor (dvs_r),
        .rem_nx  (rem_nx_s),
        .quo_nx  (quo_nx_s)
    );

    // Sequencer, operand/partial-result registers and HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            prod_r  <= {(2*DATA_W){1'b0}};
            quo_r   <= {DATA_W{1'b0}};
            rem_r   <= {DATA_W{1'b0}};
            dvs_r   <= {DATA_W{1'b0}};
            raw_a_r <= {DATA_W{1'b0}};
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
            hi_r    <= {DATA_W{1'b0}};
            lo_r    <= {DATA_W{1'b0}};
        end else if (flush) begin
            // Abort: partial results are simply abandoned, HI/LO untouched.
            state_r <= ST_IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid) begin
                        case (op_s)
                            OP_MULT, OP_MULTU: begin
                                prod_r  <= prod_s;
                                state_r <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                quo_r   <= cond_neg(src_a, div_signed_s & src_a[DATA_W-1]);
                                dvs_r   <= cond_neg(src_b, div_signed_s & src_b[DATA_W-1]);
                                rem_r   <= {DATA_W{1'b0}};
                                raw_a_r <= src_a;
                                qneg_r  <= div_signed_s & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                                rneg_r  <= div_signed_s & src_a[DATA_W-1];
                                count_r <= {CNT_W{1'b0}};
                                state_r <= ST_DIV;
                            end
                            OP_MTHI: hi_r <= src_a;
                            OP_MTLO: lo_r <= src_a;
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_MUL: begin
                    hi_r    <= prod_r[2*DATA_W-1:DATA_W];
                    lo_r    <= prod_r[DATA_W-1:0];
                    state_r <= ST_IDLE;
                end
                ST_DIV: begin
                    rem_r   <= rem_nx_s;
                    quo_r   <= quo_nx_s;
                    count_r <= count_r + CNT_ONE;
                    if (count_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // DONE never re-issues: the divide still sits in EX here.
                    if (dvs_r == {DATA_W{1'b0}}) begin
                        hi_r <= raw_a_r;
                        lo_r <= DIV_ZERO_LO;
                    end else begin
                        hi_r <= cond_neg(rem_r, rneg_r);
                        lo_r <= cond_neg(quo_r, qneg_r);
                    end
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign stall_e = stall_s;
    assign busy    = (state_r != ST_IDLE);
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_mdu_ctrl
// Directed scenarios with literal expectations, followed by randomized traffic.
// A behavioural model tracks HI/LO and "cycles remaining" for the operation in
// flight, computing results with plain integer arithmetic at issue time.
// ---------------------------------------------------------------------------
module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        stall_e;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;

    // model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_res_hi = 32'd0;
    logic [31:0] m_res_lo = 32'd0;
    int          m_left = 0;
    bit          m_isdiv = 1'b0;
    bit          chk_en = 1'b0;

    hilo_mdu_ctrl #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ex_valid (ex_valid),
        .mdu_op   (mdu_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .stall_e  (stall_e),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_start(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic bit exp_stall();
        return !flush && ((m_left == 0 && ex_valid && is_start(mdu_op)) ||
                          (m_isdiv && m_left > 1));
    endfunction

    task automatic model_issue();
        int          ia;
        int          ib;
        longint      ps;
        logic [63:0] pu;
        ia = src_a;
        ib = src_b;
        case (mdu_op)
            3'd1: begin
                ps = longint'(ia) * longint'(ib);
                {m_res_hi, m_res_lo} = ps;
                m_left = 1; m_isdiv = 1'b0;
            end
            3'd2: begin
                pu = {32'd0, src_a} * {32'd0, src_b};
                {m_res_hi, m_res_lo} = pu;
                m_left = 1; m_isdiv = 1'b0;
            end
            3'd3: begin
                if (src_b == 32'd0) begin
                    m_res_hi = src_a; m_res_lo = 32'hFFFF_FFFF;
                end else if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
                    m_res_hi = 32'd0; m_res_lo = 32'h8000_0000;
                end else begin
                    m_res_lo = ia / ib;
                    m_res_hi = ia % ib;
                end
                m_left = 33; m_isdiv = 1'b1;
            end
            3'd4: begin
                if (src_b == 32'd0) begin
                    m_res_hi = src_a; m_res_lo = 32'hFFFF_FFFF;
                end else begin
                    m_res_lo = src_a / src_b;
                    m_res_hi = src_a % src_b;
                end
                m_left = 33; m_isdiv = 1'b1;
            end
            3'd5: m_hi = src_a;
            3'd6: m_lo = src_a;
            default: ;
        endcase
    endtask

    // behavioural model, advanced on every active edge
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_isdiv = 1'b0;
            end else if (flush) begin
                m_left = 0;
            end else if (m_left == 0) begin
                if (ex_valid) model_issue();
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_res_hi;
                    m_lo = m_res_lo;
                end
            end
        end
    end

    // compare process, on the inactive edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("stall_e", {31'd0, stall_e}, {31'd0, exp_stall()});
                check("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
                check("hi", hi, m_hi);
                check("lo", lo, m_lo);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic set_in(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1; mdu_op = op; src_a = a; src_b = b;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; mdu_op = 3'd0;
    endtask

    // Issue an op and hold it in EX until the unit is idle again.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input int exp_stalls);
        int cyc;
        int stl;
        cyc = 0; stl = 0;
        set_in(op, a, b);
        do begin
            #1;
            if (stall_e) stl++;
            cyc++;
            @(posedge clk);
            #3;
        end while (busy && cyc < 40);
        check("occupancy", cyc, exp_cycles);
        check("stall_count", stl, exp_stalls);
        idle_in();
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #3;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_e}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // multiply
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 2, 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 2, 1);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // divide
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 34, 33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd100, 32'd7, 34, 33);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        run_op(3'd4, 32'h0000_1234, 32'd0, 34, 33);
        check("dz_hi", hi, 32'h0000_1234);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 34, 33);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // flush mid-divide at cycle 10
        set_in(3'd3, 32'd100, 32'd3);
        repeat (10) tick();
        check("pre_flush_stall", {31'd0, stall_e}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_e}, 32'd0);
        tick();
        flush = 1'b0;
        idle_in();
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'h8000_0000);

        // flush in the DONE cycle
        set_in(3'd4, 32'd50, 32'd7);
        repeat (33) tick();
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_stall", {31'd0, stall_e}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        check("done_flush_busy", {31'd0, busy}, 32'd0);
        check("done_flush_hi", hi, 32'd0);
        check("done_flush_lo", lo, 32'h8000_0000);

        // MTHI / MTLO
        set_in(3'd5, 32'hDEAD_BEEF, 32'd0);
        #1;
        check("mthi_stall", {31'd0, stall_e}, 32'd0);
        tick();
        set_in(3'd6, 32'd1, 32'd0);
        #1;
        check("mtlo_stall", {31'd0, stall_e}, 32'd0);
        tick();
        idle_in();
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mtlo_lo", lo, 32'd1);
        set_in(3'd5, 32'h1234_5678, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(3'd7, 32'd5, 32'd5);
        tick();
        idle_in();
        check("mthi_flush_hi", hi, 32'hDEAD_BEEF);
        check("op7_busy", {31'd0, busy}, 32'd0);

        // back-to-back divides
        run_op(3'd4, 32'd9, 32'd2, 34, 33);
        run_op(3'd4, 32'd8, 32'd3, 34, 33);
        check("b2b_lo", lo, 32'd2);
        check("b2b_hi", hi, 32'd2);

        // asynchronous reset mid-divide
        set_in(3'd3, 32'd1000, 32'd7);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        idle_in();
        #2;
        rst = 1'b0;
        tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            flush = ($urandom_range(0, 59) == 0);
            if (m_left != 0) begin
                ex_valid = ($urandom_range(0, 3) != 0);
            end else begin
                ex_valid = ($urandom_range(0, 4) != 0);
                mdu_op   = 3'($urandom_range(0, 7));
                src_a    = rnd_operand();
                src_b    = rnd_operand();
            end
            tick();
        end
        flush = 1'b0;
        idle_in();
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
